// File: rtl/tdm_demux_4.sv
// Four-channel bit-serial TDM demultiplexer: hunts for frame_sync, then deals MSB-first slots to ch0..ch3.
// Define TDM_DEMUX_PARITY_EN for a trailing even-parity bit per slot and the parity_err output.
module tdm_demux_4 #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_bit,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [WORD_W-1:0] ch0_data,
    output logic [WORD_W-1:0] ch1_data,
    output logic [WORD_W-1:0] ch2_data,
    output logic [WORD_W-1:0] ch3_data,
    output logic [3:0]        ch_valid,
    output logic              frame_done,
`ifdef TDM_DEMUX_PARITY_EN
    output logic              sync_err,
    output logic              parity_err
`else
    output logic              sync_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOT_BITS = WORD_W + 1;
`else
    localparam int unsigned SLOT_BITS = WORD_W;
`endif
    localparam int unsigned    CNT_W    = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_BITS - 1);

    typedef enum logic {
        HUNT,
        RX
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic [1:0]        slot_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [WORD_W-1:0] word_d;
    logic [WORD_W-1:0] ch_q [4];
    logic [3:0]        ch_valid_q;
    logic              frame_done_q;
    logic              sync_err_q;

    logic frame_start;
    logic slot_end;
    logic hunt_sync;
    logic lost_sync;
    logic resync;
    logic take_bit;
    logic word_done;
    logic load_first;

    always_comb begin
        frame_start = (slot_q == 2'd0) && (bit_cnt_q == '0);
        slot_end    = (bit_cnt_q == LAST_CNT);
        hunt_sync   = (state_q == HUNT) && din_valid && frame_sync;
        lost_sync   = (state_q == RX) && din_valid && frame_start && !frame_sync;
        resync      = (state_q == RX) && din_valid && frame_sync && !frame_start;
        take_bit    = (state_q == RX) && din_valid && !lost_sync && !resync;
        word_done   = take_bit && slot_end;
        load_first  = hunt_sync || resync;
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        shift_d     = {shift_q[WORD_W-2:0], din_bit};
        word_d      = shift_d;
`ifdef TDM_DEMUX_PARITY_EN
        // the trailing parity bit is checked but never enters the shift register
        if (bit_cnt_q >= CNT_W'(WORD_W)) begin
            shift_d = shift_q;
        end
        word_d = shift_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            slot_q       <= '0;
            shift_q      <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= lost_sync || resync;
            unique case (state_q)
                HUNT: begin
                    if (hunt_sync) begin
                        state_q   <= RX;
                        bit_cnt_q <= CNT_W'(1);
                        slot_q    <= '0;
                        shift_q   <= WORD_W'(din_bit);
                    end
                end
                RX: begin
                    if (lost_sync) begin
                        state_q <= HUNT;
                    end else if (resync) begin
                        bit_cnt_q <= CNT_W'(1);
                        slot_q    <= '0;
                        shift_q   <= WORD_W'(din_bit);
                    end else if (word_done) begin
                        ch_q[slot_q] <= word_d;
                        ch_valid_q   <= 4'b0001 << slot_q;
                        frame_done_q <= (slot_q == 2'd3);
                        bit_cnt_q    <= '0;
                        slot_q       <= slot_q + 2'd1;
                        shift_q      <= shift_d;
                    end else if (take_bit) begin
                        bit_cnt_q <= bit_cnt_d;
                        shift_q   <= shift_d;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_q;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            if (load_first) begin
                par_q <= din_bit;
            end else if (word_done) begin
                par_q        <= 1'b0;
                parity_err_q <= par_q ^ din_bit;
            end else if (take_bit) begin
                par_q <= par_q ^ din_bit;
            end
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign ch0_data   = ch_q[0];
    assign ch1_data   = ch_q[1];
    assign ch2_data   = ch_q[2];
    assign ch3_data   = ch_q[3];
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: directed scenarios plus randomized frames against a queue-based model.
module tb_tdm_demux_4;
    localparam int unsigned W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SB = W + 1;
    localparam int unsigned OW = 4 * W + 7;
`else
    localparam int unsigned SB = W;
    localparam int unsigned OW = 4 * W + 6;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         din_bit;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] ch0_data;
    logic [W-1:0] ch1_data;
    logic [W-1:0] ch2_data;
    logic [W-1:0] ch3_data;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic         parity_err;
    logic [3:0]   flip;
    bit           m_perr;
`endif

    tdm_demux_4 #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_bit    (din_bit),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .ch2_data   (ch2_data),
        .ch3_data   (ch3_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
`ifdef TDM_DEMUX_PARITY_EN
        .sync_err   (sync_err),
        .parity_err (parity_err)
`else
        .sync_err   (sync_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic v;
        logic s;
        logic r;
    } stim_t;

    stim_t       stim[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned stall_pct = 0;

    // Reference model: bits of the current slot collect in a queue and are folded once the slot is full.
    bit           m_hunt;
    int           m_slot;
    bit           m_cur[$];
    logic [W-1:0] m_ch[4];
    logic [3:0]   m_valid;
    bit           m_fd;
    bit           m_serr;

    function automatic stim_t mk(logic b, logic v, logic s, logic r);
        stim_t x;
        x.b = b; x.v = v; x.s = s; x.r = r;
        return x;
    endfunction

    task automatic model_step(stim_t x);
        int unsigned word;
        int          par;
        m_valid = '0; m_fd = 0; m_serr = 0;
`ifdef TDM_DEMUX_PARITY_EN
        m_perr = 0;
`endif
        if (x.r) begin
            m_hunt = 1; m_slot = 0; m_cur.delete();
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
            return;
        end
        if (!x.v) return;
        if (m_hunt) begin
            if (x.s) begin
                m_hunt = 0; m_slot = 0; m_cur.delete(); m_cur.push_back(x.b);
            end
            return;
        end
        if (m_slot == 0 && m_cur.size() == 0) begin
            if (!x.s) begin
                m_serr = 1; m_hunt = 1;
                return;
            end
        end else if (x.s) begin
            m_serr = 1; m_slot = 0; m_cur.delete(); m_cur.push_back(x.b);
            return;
        end
        m_cur.push_back(x.b);
        if (m_cur.size() == SB) begin
            word = 0;
            par  = 0;
            for (int i = 0; i < int'(W); i++) word = word * 2 + m_cur[i];
            for (int i = 0; i < int'(SB); i++) par = par ^ int'(m_cur[i]);
            m_ch[m_slot]    = W'(word);
            m_valid[m_slot] = 1'b1;
            m_fd            = (m_slot == 3);
`ifdef TDM_DEMUX_PARITY_EN
            m_perr = (par != 0);
`endif
            m_slot = (m_slot + 1) % 4;
            m_cur.delete();
        end
    endtask

    task automatic drive(stim_t x);
        din_bit = x.b; din_valid = x.v; frame_sync = x.s; rst = x.r;
        @(posedge clk);
        model_step(x);
        #1;
    endtask

    function automatic logic [OW-1:0] got_o();
`ifdef TDM_DEMUX_PARITY_EN
        return {ch3_data, ch2_data, ch1_data, ch0_data, ch_valid, frame_done, sync_err, parity_err};
`else
        return {ch3_data, ch2_data, ch1_data, ch0_data, ch_valid, frame_done, sync_err};
`endif
    endfunction

    function automatic logic [OW-1:0] exp_o();
`ifdef TDM_DEMUX_PARITY_EN
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_valid, m_fd, m_serr, m_perr};
`else
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_valid, m_fd, m_serr};
`endif
    endfunction

    task automatic push_bit(logic b, logic s);
        while ($urandom_range(99, 0) < stall_pct)
            stim.push_back(mk(1'($urandom), 1'b0, 1'($urandom), 1'b0));
        stim.push_back(mk(b, 1'b1, s, 1'b0));
    endtask

    task automatic push_word(logic [W-1:0] w, logic sync, int slot);
        for (int i = int'(W) - 1; i >= 0; i--) push_bit(w[i], sync && (i == int'(W) - 1));
`ifdef TDM_DEMUX_PARITY_EN
        push_bit((^w) ^ flip[slot], 1'b0);
`else
        if (slot < 0) push_bit(1'b0, 1'b0);
`endif
    endtask

    task automatic push_frame(logic [3:0][W-1:0] w, logic sync);
        for (int k = 0; k < 4; k++) push_word(w[k], sync && (k == 0), k);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'($urandom), 1'b1, 1'b1, 1'b1));
            n_tests++;
            if (got_o() !== '0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%h required=0", i, got_o());
            end
        end
    endtask

    task automatic test_single_frame();
        logic [3:0][W-1:0] w = {8'h01, 8'hFF, 8'h3C, 8'hA5};
        int pc[$]; logic [3:0] pv[$]; int fd_cyc = -1; int cyc = 0;
        stall_pct = 0;
        push_frame(w, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (ch_valid !== 4'b0) begin pc.push_back(cyc); pv.push_back(ch_valid); end
            if (frame_done === 1'b1) fd_cyc = cyc;
            cyc++;
        end
        n_tests++;
        if (pc.size() != 4) begin
            n_fail++;
            $display("FAIL single_frame_pulses got=%0d required=4", pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (pc[k] != int'(SB) * (k + 1) - 1 || pv[k] !== 4'(1 << k)) begin
                    n_fail++;
                    $display("FAIL single_frame_pulse%0d got=cyc%0d/%b required=cyc%0d/%b",
                             k, pc[k], pv[k], int'(SB) * (k + 1) - 1, 4'(1 << k));
                end
            end
            n_tests++;
            if (fd_cyc != pc[3]) begin
                n_fail++;
                $display("FAIL single_frame_done got=%0d required=%0d", fd_cyc, pc[3]);
            end
        end
        n_tests++;
        if ({ch3_data, ch2_data, ch1_data, ch0_data} !== 32'h01FF3CA5) begin
            n_fail++;
            $display("FAIL single_frame_data got=%h required=01ff3ca5", {ch3_data, ch2_data, ch1_data, ch0_data});
        end
    endtask

    task automatic test_stall();
        logic [3:0][W-1:0] w = {8'h01, 8'hFF, 8'h3C, 8'hA5};
        int pc[$]; int cyc = 0;
        stall_pct = 0;
        push_frame(w, 1'b1);
        for (int i = 0; i < 3; i++) stim.insert(SB + 4, mk(1'($urandom), 1'b0, 1'b1, 1'b0));
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (ch_valid !== 4'b0) pc.push_back(cyc);
            cyc++;
        end
        n_tests++;
        if (pc.size() != 4) begin
            n_fail++;
            $display("FAIL stall_pulses got=%0d required=4", pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (pc[k] != int'(SB) * (k + 1) - 1 + (k > 0 ? 3 : 0)) begin
                    n_fail++;
                    $display("FAIL stall_pulse%0d got=%0d required=%0d", k, pc[k],
                             int'(SB) * (k + 1) - 1 + (k > 0 ? 3 : 0));
                end
            end
        end
        n_tests++;
        if ({ch3_data, ch2_data, ch1_data, ch0_data} !== 32'h01FF3CA5) begin
            n_fail++;
            $display("FAIL stall_data got=%h required=01ff3ca5", {ch3_data, ch2_data, ch1_data, ch0_data});
        end
    endtask

    task automatic test_resync();
        logic [3:0][W-1:0] a = {8'h44, 8'h33, 8'h22, 8'h11};
        logic [3:0][W-1:0] b = {8'hD4, 8'hC3, 8'hB2, 8'h9E};
        int serr_n = 0; int serr_cyc = -1; int v2_n = 0; int cyc = 0;
        stall_pct = 0;
        push_frame(a, 1'b1);
        while (stim.size() > 2 * SB + 4) void'(stim.pop_back());
        push_frame(b, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL resync cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (sync_err === 1'b1) begin serr_n++; serr_cyc = cyc; end
            if (ch_valid[2] === 1'b1) v2_n++;
            cyc++;
        end
        n_tests++;
        if (serr_n != 1 || serr_cyc != 2 * int'(SB) + 4) begin
            n_fail++;
            $display("FAIL resync_err got=%0d@%0d required=1@%0d", serr_n, serr_cyc, 2 * int'(SB) + 4);
        end
        n_tests++;
        if (v2_n != 1) begin
            n_fail++;
            $display("FAIL resync_ch2_pulses got=%0d required=1", v2_n);
        end
        n_tests++;
        if ({ch3_data, ch2_data, ch1_data, ch0_data} !== b) begin
            n_fail++;
            $display("FAIL resync_data got=%h required=%h", {ch3_data, ch2_data, ch1_data, ch0_data}, b);
        end
    endtask

    task automatic test_no_sync();
        logic [3:0][W-1:0] a = {8'h5A, 8'h80, 8'h7F, 8'hC6};
        logic [3:0][W-1:0] b = {8'h12, 8'h34, 8'h56, 8'h78};
        logic [3:0][W-1:0] c = {8'hE1, 8'h0F, 8'h99, 8'h6B};
        int serr_n = 0; int serr_cyc = -1; int gap_pulses = 0; int cyc = 0;
        logic [4*W-1:0] held = '0;
        stall_pct = 0;
        push_frame(a, 1'b1);
        push_frame(b, 1'b0);
        push_frame(c, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL no_sync cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (sync_err === 1'b1) begin serr_n++; serr_cyc = cyc; end
            if (cyc >= 4 * int'(SB) && cyc < 8 * int'(SB) && ch_valid !== 4'b0) gap_pulses++;
            if (cyc == 8 * int'(SB) - 1) held = {ch3_data, ch2_data, ch1_data, ch0_data};
            cyc++;
        end
        n_tests++;
        if (serr_n != 1 || serr_cyc != 4 * int'(SB)) begin
            n_fail++;
            $display("FAIL no_sync_err got=%0d@%0d required=1@%0d", serr_n, serr_cyc, 4 * int'(SB));
        end
        n_tests++;
        if (gap_pulses != 0 || held !== a) begin
            n_fail++;
            $display("FAIL no_sync_hold got=%0d/%h required=0/%h", gap_pulses, held, a);
        end
        n_tests++;
        if ({ch3_data, ch2_data, ch1_data, ch0_data} !== c) begin
            n_fail++;
            $display("FAIL no_sync_next got=%h required=%h", {ch3_data, ch2_data, ch1_data, ch0_data}, c);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0][W-1:0] a = {8'h0C, 8'hB7, 8'h2D, 8'hF0};
        logic [3:0][W-1:0] d = {8'h3E, 8'h71, 8'hA9, 8'h48};
        stim_t x; int post_pulses = 0; bit after = 0; int cyc = 0;
        stall_pct = 0;
        push_frame(a, 1'b1);
        stim[SB + 5] = mk(1'b1, 1'b1, 1'b0, 1'b1);
        push_frame(d, 1'b1);
        while (stim.size() > 0) begin
            x = stim.pop_front();
            drive(x);
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (x.r) begin
                after = 1;
                n_tests++;
                if (got_o() !== '0) begin
                    n_fail++;
                    $display("FAIL mid_reset_zero got=%h required=0", got_o());
                end
            end else if (after && ch_valid !== 4'b0) begin
                post_pulses++;
            end
            cyc++;
        end
        n_tests++;
        if (post_pulses != 4 || {ch3_data, ch2_data, ch1_data, ch0_data} !== d) begin
            n_fail++;
            $display("FAIL mid_reset_next got=%0d/%h required=4/%h", post_pulses,
                     {ch3_data, ch2_data, ch1_data, ch0_data}, d);
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        logic [3:0][W-1:0] w = {8'h44, 8'h22, 8'h11, 8'h07};
        int perr_n = 0; int perr_ok = 0; int cyc = 0;
        stall_pct = 0;
        flip = 4'b0001;
        push_frame(w, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL parity cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            if (parity_err === 1'b1) begin
                perr_n++;
                if (ch_valid === 4'b0001 && ch0_data === 8'h07) perr_ok++;
            end
            cyc++;
        end
        n_tests++;
        if (perr_n != 1 || perr_ok != 1) begin
            n_fail++;
            $display("FAIL parity_bad got=%0d/%0d required=1/1", perr_n, perr_ok);
        end
        flip = 4'b0000;
        perr_n = 0;
        push_frame(w, 1'b1);
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            if (parity_err === 1'b1) perr_n++;
        end
        n_tests++;
        if (perr_n != 0 || ch0_data !== 8'h07) begin
            n_fail++;
            $display("FAIL parity_good got=%0d/%h required=0/07", perr_n, ch0_data);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0][W-1:0] w;
        int unsigned kind, base, idx;
        stim_t t;
        int cyc = 0;
        stall_pct = 20;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 4; k++) w[k] = W'($urandom);
`ifdef TDM_DEMUX_PARITY_EN
            flip = 4'($urandom) & 4'($urandom);
`endif
            kind = $urandom_range(9, 0);
            base = stim.size();
            push_frame(w, kind != 1);
            if (kind == 2) begin
                idx = base + 1 + $urandom_range(stim.size() - base - 2, 0);
                t = stim[idx]; t.s = 1'b1; stim[idx] = t;
            end
            if (kind == 3) begin
                idx = base + $urandom_range(stim.size() - base - 1, 0);
                stim[idx] = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end
        while (stim.size() > 0) begin
            drive(stim.pop_front());
            n_tests++;
            if (got_o() !== exp_o()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_o(), exp_o());
            end
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; din_bit = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        flip = 4'b0000;
`endif
        test_reset();
        test_single_frame();
        test_stall();
        test_resync();
        test_no_sync();
        test_mid_reset();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
